// File: rtl/cr_cmd_decoder.sv
// Correlator command decoder: queues host commands and issues one-cycle core strobes, two cycles after we.
// One command per 2 cycles (plus clk-gen ack wait); writes while full are dropped and flagged in err_ovf.
module cr_cmd_decoder #(
   parameter int N_CH   = 4,
   parameter int DW     = 16,
   parameter int DEPTH  = 4,
   parameter int TO_CYC = 255,
   localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [3:0]      opcode,
   input  logic [CHW-1:0]  chan,
   input  logic [DW-1:0]   wdata,
   output logic            full,
   output logic            busy,
   output logic            start,
   output logic            stop,
   output logic            sw_rst,
   output logic [N_CH-1:0] we_lpf,
   output logic            we_htf,
   output logic            we_clk_gen,
   output logic [DW-1:0]   cmd_data,
   input  logic            clk_gen_ack,
   output logic            running,
   input  logic            err_clr,
   output logic            err_illegal,
   output logic            err_ovf,
   output logic            err_tmo
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = $clog2(TO_CYC + 1);

   localparam logic [3:0] OP_STOP    = 4'd0;
   localparam logic [3:0] OP_START   = 4'd1;
   localparam logic [3:0] OP_SW_RST  = 4'd2;
   localparam logic [3:0] OP_LPF_WE  = 4'd4;
   localparam logic [3:0] OP_HTF_WE  = 4'd6;
   localparam logic [3:0] OP_CLK_GEN = 4'd8;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ISSUE    = 2'd1;
   localparam logic [1:0] S_WAIT_ACK = 2'd2;

   localparam logic [CHW:0] N_CH_V = (CHW + 1)'(N_CH);

   typedef struct packed {
      logic [3:0]     op;
      logic [CHW-1:0] chan;
      logic [DW-1:0]  data;
   } cmd_t;

   cmd_t           mem_q [DEPTH];
   cmd_t           mem_d [DEPTH];
   cmd_t           cmd_q, cmd_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [1:0]     state_q, state_d;
   logic [TW-1:0]  cnt_q, cnt_d;
   logic           running_q, running_d;
   logic           err_illegal_q, err_illegal_d;
   logic           err_ovf_q, err_ovf_d;
   logic           err_tmo_q, err_tmo_d;

   logic           empty, push, op_valid, cmd_legal, fire, ill_ev, tmo_ev, ovf_ev;

   // Full is taken from the pointers alone, so a same-cycle pop never makes room for a push.
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push   = we && !full;
   assign ovf_ev = we && full;
   assign busy   = !empty || (state_q != S_IDLE);

   assign op_valid  = (cmd_q.op == OP_STOP)   || (cmd_q.op == OP_START)  || (cmd_q.op == OP_SW_RST) ||
                      (cmd_q.op == OP_LPF_WE) || (cmd_q.op == OP_HTF_WE) || (cmd_q.op == OP_CLK_GEN);
   assign cmd_legal = op_valid && ((cmd_q.op != OP_LPF_WE) || ({1'b0, cmd_q.chan} < N_CH_V));
   assign fire      = (state_q == S_ISSUE) && cmd_legal;

   assign start      = fire && (cmd_q.op == OP_START);
   assign stop       = fire && (cmd_q.op == OP_STOP);
   assign sw_rst     = fire && (cmd_q.op == OP_SW_RST);
   assign we_htf     = fire && (cmd_q.op == OP_HTF_WE);
   assign we_clk_gen = fire && (cmd_q.op == OP_CLK_GEN);
   assign we_lpf     = (fire && (cmd_q.op == OP_LPF_WE)) ? (N_CH'(1) << cmd_q.chan) : '0;
   assign cmd_data   = cmd_q.data;

   assign running     = running_q;
   assign err_illegal = err_illegal_q;
   assign err_ovf     = err_ovf_q;
   assign err_tmo     = err_tmo_q;

   always_comb begin
      mem_d     = mem_q;
      cmd_d     = cmd_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      running_d = running_q;
      ill_ev    = 1'b0;
      tmo_ev    = 1'b0;

      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = '{op: opcode, chan: chan, data: wdata};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               cmd_d    = mem_q[rd_ptr_q[AW-1:0]];
               rd_ptr_d = rd_ptr_q + PW'(1);
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_IDLE;
            if (!cmd_legal) begin
               ill_ev = 1'b1;
            end else begin
               case (cmd_q.op)
                  OP_START:  running_d = 1'b1;
                  OP_STOP:   running_d = 1'b0;
                  OP_SW_RST: begin
                     running_d = 1'b0;
                     // Flush to the pre-push write pointer so a same-cycle push survives.
                     rd_ptr_d  = wr_ptr_q;
                  end
                  OP_CLK_GEN: begin
                     state_d = S_WAIT_ACK;
                     cnt_d   = '0;
                  end
                  default: ;
               endcase
            end
         end
         S_WAIT_ACK: begin
            cnt_d = cnt_q + TW'(1);
            if (clk_gen_ack) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_d == TW'(TO_CYC)) begin
               tmo_ev  = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      err_illegal_d = (err_illegal_q && !err_clr) || ill_ev;
      err_ovf_d     = (err_ovf_q && !err_clr) || ovf_ev;
      err_tmo_d     = (err_tmo_q && !err_clr) || tmo_ev;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q         <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         running_q     <= 1'b0;
         err_illegal_q <= 1'b0;
         err_ovf_q     <= 1'b0;
         err_tmo_q     <= 1'b0;
      end else begin
         cmd_q         <= cmd_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         running_q     <= running_d;
         err_illegal_q <= err_illegal_d;
         err_ovf_q     <= err_ovf_d;
         err_tmo_q     <= err_tmo_d;
      end
   end

endmodule
